// File: rtl/cnu_min_sum_array.sv
// Bank of six min-sum check-node units: a 2-stage valid/ready pipeline (sign/magnitude, then min/idx/sign combine).
// Define CNU_OFFSET_EN to build the offset min-sum variant; otherwise plain min-sum.
module cnu_min_sum_array #(
  parameter int DATA_WIDTH = 6,
  parameter int OFFSET     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in  [0:35],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out [0:35],
  output logic [5:0]            out_parity
);

  localparam int N_GRP = 6;
  localparam int GRP   = 6;
  localparam int N_MSG = N_GRP * GRP;
  localparam int MW    = DATA_WIDTH - 1;
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {MW{1'b0}}};
`ifdef CNU_OFFSET_EN
  localparam logic [MW-1:0] OFF_V = MW'(OFFSET);
`else
  // Plain min-sum: OFFSET is multiplied out so the subtraction below is an identity.
  localparam logic [MW-1:0] OFF_V = MW'(OFFSET * 0);
`endif

  logic          s1_valid_q;
  logic          s1_sign_q [N_MSG];
  logic [MW-1:0] s1_mag_q  [N_MSG];
  logic [MW-1:0] s1_mag_d  [N_MSG];

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] data_out_q [N_MSG];
  logic [DATA_WIDTH-1:0] data_out_d [N_MSG];
  logic [N_GRP-1:0]      parity_q;
  logic [N_GRP-1:0]      parity_d;

  logic [MW-1:0] min1_w [N_GRP];
  logic [MW-1:0] min2_w [N_GRP];
  logic [2:0]    idx_w  [N_GRP];
  logic          sgn_w  [N_GRP];

  logic s2_adv;
  logic accept;

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;

  // |x| with the most negative code saturating to the largest positive magnitude.
  always_comb begin
    for (int i = 0; i < N_MSG; i++) begin
      if (data_in[i] == MIN_NEG)
        s1_mag_d[i] = '1;
      else if (data_in[i][MW])
        s1_mag_d[i] = MW'(~data_in[i] + 1'b1);
      else
        s1_mag_d[i] = data_in[i][MW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      for (int i = 0; i < N_MSG; i++) begin
        s1_sign_q[i] <= 1'b0;
        s1_mag_q[i]  <= '0;
      end
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (accept) begin
        for (int i = 0; i < N_MSG; i++) begin
          s1_sign_q[i] <= data_in[i][MW];
          s1_mag_q[i]  <= s1_mag_d[i];
        end
      end
    end
  end

  // Strict '<' keeps the lowest index on ties; min2 skips only that one position.
  always_comb begin
    for (int g = 0; g < N_GRP; g++) begin
      min1_w[g] = '1;
      min2_w[g] = '1;
      idx_w[g]  = 3'd0;
      sgn_w[g]  = 1'b0;
      for (int j = 0; j < GRP; j++) begin
        if (s1_mag_q[g*GRP+j] < min1_w[g]) begin
          min1_w[g] = s1_mag_q[g*GRP+j];
          idx_w[g]  = 3'(j);
        end
        sgn_w[g] = sgn_w[g] ^ s1_sign_q[g*GRP+j];
      end
      for (int j = 0; j < GRP; j++) begin
        if (3'(j) != idx_w[g] && s1_mag_q[g*GRP+j] < min2_w[g])
          min2_w[g] = s1_mag_q[g*GRP+j];
      end
    end
  end

  always_comb begin : out_calc
    logic [MW-1:0]         mag_v;
    logic [DATA_WIDTH-1:0] ext_v;
    logic                  neg_v;
    mag_v = '0;
    ext_v = '0;
    neg_v = 1'b0;
    for (int g = 0; g < N_GRP; g++)
      parity_d[g] = ~sgn_w[g];
    for (int i = 0; i < N_MSG; i++) begin
      mag_v = (3'(i % GRP) == idx_w[i / GRP]) ? min2_w[i / GRP] : min1_w[i / GRP];
      mag_v = (mag_v > OFF_V) ? (mag_v - OFF_V) : '0;
      ext_v = {1'b0, mag_v};
      neg_v = sgn_w[i / GRP] ^ s1_sign_q[i];
      // Negating a zero magnitude yields zero, so no signed-zero special case is needed.
      data_out_d[i] = neg_v ? (~ext_v + 1'b1) : ext_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      parity_q    <= '0;
      for (int i = 0; i < N_MSG; i++)
        data_out_q[i] <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        parity_q <= parity_d;
        for (int i = 0; i < N_MSG; i++)
          data_out_q[i] <= data_out_d[i];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_parity = parity_q;
  always_comb begin
    for (int i = 0; i < N_MSG; i++)
      data_out[i] = data_out_q[i];
  end

endmodule

// File: tb/tb_cnu_min_sum_array.sv
// Directed bench for cnu_min_sum_array; expectations switch with CNU_OFFSET_EN.
module tb_cnu_min_sum_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] data_in  [0:35];
  logic       out_valid;
  logic       out_ready;
  logic [5:0] data_out [0:35];
  logic [5:0] out_parity;

  logic [5:0] exp_d [0:35];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cnu_min_sum_array #(.DATA_WIDTH(6), .OFFSET(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .out_parity(out_parity)
  );

  task automatic set_all(input int v);
    for (int i = 0; i < 36; i++) data_in[i] = 6'(v);
  endtask

  task automatic exp_all(input int v);
    for (int i = 0; i < 36; i++) exp_d[i] = 6'(v);
  endtask

  function automatic int diff_idx();
    for (int i = 0; i < 36; i++)
      if (data_out[i] !== exp_d[i]) return i;
    return -1;
  endfunction

  // Present the frame for one edge, then wait one more edge so it sits in the output register.
  task automatic send_frame();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int di;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; set_all(0);
    repeat (2) @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_parity !== 6'd0) begin errors++; $display("FAIL reset_parity got %b want 000000", out_parity); end
    exp_all(0); di = diff_idx();
    checks++; if (di >= 0) begin errors++; $display("FAIL reset_data idx %0d got %0d want 0", di, data_out[di]); end
    rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    // Fill both stages, then reset asynchronously between edges.
    set_all(7); in_valid = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midreset_pre_valid got %b want 1", out_valid); end
    #2 rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b want 0", out_valid); end
    checks++; if (out_parity !== 6'd0) begin errors++; $display("FAIL midreset_parity got %b want 000000", out_parity); end
    di = diff_idx();
    checks++; if (di >= 0) begin errors++; $display("FAIL midreset_data idx %0d got %0d want 0", di, data_out[di]); end
    in_valid = 1'b0; #2 rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_flush cycle %0d got %b want 0", c, out_valid); end
    end
    $display("reset transaction done");
  endtask

  task automatic test_basic();
    int di;
    int v[6] = '{3, -5, 7, 2, 6, 4};
`ifdef CNU_OFFSET_EN
    int e[6] = '{-1, 1, -1, -2, -1, -1};
`else
    int e[6] = '{-2, 2, -2, -3, -2, -2};
`endif
    set_all(0); exp_all(0);
    for (int j = 0; j < 6; j++) begin data_in[j] = 6'(v[j]); exp_d[j] = 6'(e[j]); end
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency1 got %b want 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency2 got %b want 1", out_valid); end
    di = diff_idx();
    checks++; if (di >= 0) begin errors++; $display("FAIL basic_data idx %0d got %0d want %0d", di, $signed(data_out[di]), $signed(exp_d[di])); end
    checks++; if (out_parity !== 6'b111110) begin errors++; $display("FAIL basic_parity got %b want 111110", out_parity); end
    $display("basic frame out: d0=%0d d3=%0d parity=%b", $signed(data_out[0]), $signed(data_out[3]), out_parity);
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    int di;
    set_all(-32);
`ifdef CNU_OFFSET_EN
    exp_all(-30);
`else
    exp_all(-31);
`endif
    send_frame();
    di = diff_idx();
    checks++; if (di >= 0) begin errors++; $display("FAIL sat_data idx %0d got %0d want %0d", di, $signed(data_out[di]), $signed(exp_d[di])); end
    checks++; if (out_parity !== 6'b111111) begin errors++; $display("FAIL sat_parity got %b want 111111", out_parity); end
    $display("saturation frame out: d0=%0d parity=%b", $signed(data_out[0]), out_parity);
    @(posedge clk); #1;
  endtask

  task automatic test_tie();
    int di;
    int a[6] = '{4, 4, 9, 9, 9, 9};
    int b[6] = '{1, 1, 5, 5, 5, 5};
    set_all(0); exp_all(0);
    for (int j = 0; j < 6; j++) begin
      data_in[12+j] = 6'(a[j]);
      data_in[24+j] = 6'(b[j]);
`ifdef CNU_OFFSET_EN
      exp_d[12+j] = 6'd3;
      exp_d[24+j] = 6'd0;
`else
      exp_d[12+j] = 6'd4;
      exp_d[24+j] = 6'd1;
`endif
    end
    send_frame();
    di = diff_idx();
    checks++; if (di >= 0) begin errors++; $display("FAIL tie_data idx %0d got %0d want %0d", di, $signed(data_out[di]), $signed(exp_d[di])); end
    checks++; if (out_parity !== 6'b111111) begin errors++; $display("FAIL tie_parity got %b want 111111", out_parity); end
    $display("tie frame out: g2=%0d g4=%0d", $signed(data_out[12]), $signed(data_out[24]));
    @(posedge clk); #1;
  endtask

  // Group g: one negative minimum at position g, all others +10.
  task automatic test_groups();
    int di;
    set_all(10);
    for (int g = 0; g < 6; g++) begin
      data_in[g*6+g] = 6'(-(g+1));
      for (int j = 0; j < 6; j++) begin
`ifdef CNU_OFFSET_EN
        exp_d[g*6+j] = (j == g) ? 6'd9 : 6'(-g);
`else
        exp_d[g*6+j] = (j == g) ? 6'd10 : 6'(-(g+1));
`endif
      end
    end
    send_frame();
    di = diff_idx();
    checks++; if (di >= 0) begin errors++; $display("FAIL groups_data idx %0d got %0d want %0d", di, $signed(data_out[di]), $signed(exp_d[di])); end
    checks++; if (out_parity !== 6'b000000) begin errors++; $display("FAIL groups_parity got %b want 000000", out_parity); end
    $display("groups frame out: d0=%0d d35=%0d parity=%b", $signed(data_out[0]), $signed(data_out[35]), out_parity);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int di;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 4);
      set_all((c + 1) * 3);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cycle %0d got %b want 1", c, in_ready); end
      @(posedge clk); #1;
      if (c >= 1 && c <= 4) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid cycle %0d got %b want 1", c, out_valid); end
`ifdef CNU_OFFSET_EN
        exp_all(c * 3 - 1);
`else
        exp_all(c * 3);
`endif
        di = diff_idx();
        checks++; if (di >= 0) begin errors++; $display("FAIL b2b_data cycle %0d idx %0d got %0d want %0d", c, di, $signed(data_out[di]), $signed(exp_d[di])); end
        $display("b2b frame %0d out: d0=%0d", c - 1, $signed(data_out[0]));
      end else if (c == 5) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    int di;
`ifdef CNU_OFFSET_EN
    int ea = 4, eb = -5, ec = 10;
`else
    int ea = 5, eb = -6, ec = 11;
`endif
    out_ready = 1'b0;
    set_all(5); in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_accept_a got %b want 1", in_ready); end
    @(posedge clk); #1;
    set_all(-6);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_accept_b got %b want 1", in_ready); end
    @(posedge clk); #1;
    set_all(11);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_block_c got %b want 0", in_ready); end
    for (int c = 0; c < 3; c++) begin
      exp_all(ea); di = diff_idx();
      checks++; if (out_valid !== 1'b1 || di >= 0) begin
        errors++; $display("FAIL stall_hold_a cycle %0d valid %b d0 got %0d want %0d", c, out_valid, $signed(data_out[0]), ea);
      end
      $display("stall cycle %0d: holding frame A d0=%0d", c, $signed(data_out[0]));
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle %0d got %b want 0", c, in_ready); end
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_all(eb); di = diff_idx();
    checks++; if (out_valid !== 1'b1 || di >= 0) begin
      errors++; $display("FAIL stall_out_b valid %b d0 got %0d want %0d", out_valid, $signed(data_out[0]), eb);
    end
    $display("stall release: frame B d0=%0d", $signed(data_out[0]));
    @(posedge clk); #1;
    exp_all(ec); di = diff_idx();
    checks++; if (out_valid !== 1'b1 || di >= 0) begin
      errors++; $display("FAIL stall_out_c valid %b d0 got %0d want %0d", out_valid, $signed(data_out[0]), ec);
    end
    $display("stall release: frame C d0=%0d", $signed(data_out[0]));
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_no_dup got %b want 0", out_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_tie();
    test_groups();
    test_back_to_back();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
